// File: rtl/poly_mem_ctrl_if.sv
// Bundled command, host-RAM and NTT-core signals of the polynomial memory controller.
// The master side (host plus core) drives requests; the slave side is the controller.
interface poly_mem_ctrl_if #(
  parameter int AW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic          cmd_add_or_sub;
  logic [AW-1:0] cmd_src_a;
  logic [AW-1:0] cmd_src_b;
  logic [AW-1:0] cmd_dst;

  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [95:0]   host_wdata;
  logic [95:0]   host_rdata;

  logic          core_start;
  logic [1:0]    core_mode;
  logic          core_add_or_sub;
  logic [AW-1:0] core_off_a;
  logic [AW-1:0] core_off_b;
  logic [AW-1:0] core_off_w;
  logic [AW-1:0] core_r_addr;
  logic [95:0]   core_r_data;
  logic [AW-1:0] core_w_addr;
  logic [95:0]   core_w_data;
  logic          core_w_en;

  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_mode, cmd_add_or_sub, cmd_src_a, cmd_src_b, cmd_dst,
    output host_we, host_addr, host_wdata,
    output core_r_addr, core_w_addr, core_w_data, core_w_en,
    input  cmd_ready, host_rdata, core_start, core_mode, core_add_or_sub,
    input  core_off_a, core_off_b, core_off_w, core_r_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_add_or_sub, cmd_src_a, cmd_src_b, cmd_dst,
    input  host_we, host_addr, host_wdata,
    input  core_r_addr, core_w_addr, core_w_data, core_w_en,
    output cmd_ready, host_rdata, core_start, core_mode, core_add_or_sub,
    output core_off_a, core_off_b, core_off_w, core_r_data, busy, done, err
  );
endinterface

// File: rtl/poly_mem_ctrl.sv
// Polynomial RAM plus command sequencer for an NTT core: host owns the RAM while idle,
// the core owns its write port while a command runs, with a cycle-budget abort.
module poly_mem_ctrl #(
  parameter int TIMEOUT = 300,
  parameter int AW      = 8
) (
  input logic           clk,
  input logic           rst,
  poly_mem_ctrl_if.slave bus_io
);

  localparam int DW    = 96;
  localparam int DEPTH = 1 << AW;
  localparam logic [8:0] CNT_LAST = 9'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic          core_start_q, core_start_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    mode_q, mode_d;
  logic          aos_q, aos_d;
  logic [AW-1:0] off_a_q, off_a_d;
  logic [AW-1:0] off_b_q, off_b_d;
  logic [AW-1:0] off_w_q, off_w_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] host_rdata_q;
  logic [DW-1:0] core_rdata_q;

  logic          ram_we_s;
  logic [AW-1:0] ram_waddr_s;
  logic [DW-1:0] ram_wdata_s;
  logic          core_owns_s;

  assign core_owns_s = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // Next-state, command latch, timeout counter and status pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    mode_d       = mode_q;
    aos_d        = aos_q;
    off_a_d      = off_a_q;
    off_b_d      = off_b_q;
    off_w_d      = off_w_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.cmd_valid) begin
          mode_d       = bus_io.cmd_mode;
          aos_d        = bus_io.cmd_add_or_sub;
          off_a_d      = bus_io.cmd_src_a;
          off_b_d      = bus_io.cmd_src_b;
          off_w_d      = bus_io.cmd_dst;
          err_d        = 1'b0;
          core_start_d = 1'b1;
          state_d      = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = 9'd0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (bus_io.core_w_en) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus_io.core_w_en) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 9'd0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mode_q       <= 2'd0;
      aos_q        <= 1'b0;
      off_a_q      <= '0;
      off_b_q      <= '0;
      off_w_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      mode_q       <= mode_d;
      aos_q        <= aos_d;
      off_a_q      <= off_a_d;
      off_b_q      <= off_b_d;
      off_w_q      <= off_w_d;
    end
  end

  // Single RAM write port: host while idle, core while a command runs.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = bus_io.host_addr;
    ram_wdata_s = bus_io.host_wdata;
    if ((state_q == ST_IDLE) && bus_io.host_we) begin
      ram_we_s = 1'b1;
    end else if (core_owns_s && bus_io.core_w_en) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = bus_io.core_w_addr;
      ram_wdata_s = bus_io.core_w_data;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // RAM array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_waddr_s] <= ram_wdata_s;
    end
  end

  // Registered read ports; they sample the array before this cycle's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rdata_q <= '0;
      core_rdata_q <= '0;
    end else begin
      host_rdata_q <= mem_q[bus_io.host_addr];
      core_rdata_q <= mem_q[bus_io.core_r_addr];
    end
  end

  assign bus_io.cmd_ready       = (state_q == ST_IDLE);
  assign bus_io.busy            = (state_q != ST_IDLE);
  assign bus_io.core_start      = core_start_q;
  assign bus_io.done            = done_q;
  assign bus_io.err             = err_q;
  assign bus_io.core_mode       = mode_q;
  assign bus_io.core_add_or_sub = aos_q;
  assign bus_io.core_off_a      = off_a_q;
  assign bus_io.core_off_b      = off_b_q;
  assign bus_io.core_off_w      = off_w_q;
  assign bus_io.host_rdata      = host_rdata_q;
  assign bus_io.core_r_data     = core_rdata_q;

endmodule

// File: tb/tb_poly_mem_ctrl.sv
// Randomized bench for poly_mem_ctrl: a transaction-level RAM model predicts every read,
// and command sequences check handshake timing, field stability, timeout and reset abort.
module tb_poly_mem_ctrl;

  localparam int TIMEOUT = 300;
  localparam int AW      = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [95:0] mem_m [256];
  logic m_idle;
  logic m_run;
  logic chk_rd;

  poly_mem_ctrl_if #(.AW(AW)) bus_if ();

  poly_mem_ctrl #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] rand96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: model applies the write the controller should honour, then reads are compared.
  task automatic tick();
    logic [95:0] exp_h;
    logic [95:0] exp_c;
    bus_if.core_r_addr = 8'($urandom);
    exp_h = mem_m[bus_if.host_addr];
    exp_c = mem_m[bus_if.core_r_addr];
    if (!rst) begin
      if (m_idle && bus_if.host_we) mem_m[bus_if.host_addr] = bus_if.host_wdata;
      else if (m_run && bus_if.core_w_en) mem_m[bus_if.core_w_addr] = bus_if.core_w_data;
    end
    @(posedge clk);
    #1;
    if (!rst && chk_rd) begin
      check_eq("host_rd", bus_if.host_rdata, exp_h);
      check_eq("core_rd", bus_if.core_r_data, exp_c);
    end
  endtask

  task automatic check_fields(input logic [1:0] mode, input logic aos,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] w);
    check_eq("core_mode", bus_if.core_mode, mode);
    check_eq("core_aos", bus_if.core_add_or_sub, aos);
    check_eq("off_a", bus_if.core_off_a, a);
    check_eq("off_b", bus_if.core_off_b, b);
    check_eq("off_w", bus_if.core_off_w, w);
  endtask

  task automatic check_running(input logic [1:0] mode, input logic aos,
                               input logic [7:0] a, input logic [7:0] b, input logic [7:0] w);
    check_eq("run_start", bus_if.core_start, 1'b0);
    check_eq("run_busy", bus_if.busy, 1'b1);
    check_eq("run_done", bus_if.done, 1'b0);
    check_fields(mode, aos, a, b, w);
  endtask

  task automatic accept(input logic [1:0] mode, input logic aos,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] w);
    bus_if.cmd_valid      = 1'b1;
    bus_if.cmd_mode       = mode;
    bus_if.cmd_add_or_sub = aos;
    bus_if.cmd_src_a      = a;
    bus_if.cmd_src_b      = b;
    bus_if.cmd_dst        = w;
    bus_if.host_we        = 1'($urandom_range(0, 1));
    bus_if.host_addr      = 8'($urandom);
    bus_if.host_wdata     = rand96();
    tick();
    bus_if.cmd_valid = 1'b0;
    bus_if.host_we   = 1'b0;
    m_idle = 1'b0;
    check_eq("launch_start", bus_if.core_start, 1'b1);
    check_eq("launch_busy", bus_if.busy, 1'b1);
    check_eq("launch_ready", bus_if.cmd_ready, 1'b0);
    check_eq("launch_done", bus_if.done, 1'b0);
    check_eq("launch_err", bus_if.err, 1'b0);
    check_fields(mode, aos, a, b, w);
  endtask

  // Full command: core writes len beats at dst.. after dly idle cycles; host keeps poking intr.
  task automatic run_cmd(input logic [1:0] mode, input logic aos,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] w,
                         input int len, input int dly, input logic [7:0] intr, input int rst_at);
    logic aborted;
    aborted = 1'b0;
    accept(mode, aos, a, b, w);
    bus_if.host_we    = 1'b1;
    bus_if.host_addr  = intr;
    bus_if.host_wdata = rand96();
    tick();
    m_run = 1'b1;
    for (int d = 0; d < dly; d++) begin
      check_running(mode, aos, a, b, w);
      tick();
    end
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check_eq("rst_busy", bus_if.busy, 1'b0);
        check_eq("rst_done", bus_if.done, 1'b0);
        check_eq("rst_ready", bus_if.cmd_ready, 1'b1);
        check_eq("rst_mode", bus_if.core_mode, 2'd0);
        check_eq("rst_off_w", bus_if.core_off_w, 8'd0);
        check_eq("rst_hrd", bus_if.host_rdata, 96'd0);
        aborted = 1'b1;
        break;
      end
      check_running(mode, aos, a, b, w);
      bus_if.core_w_en   = 1'b1;
      bus_if.core_w_addr = 8'(int'(w) + i);
      bus_if.core_w_data = rand96();
      tick();
    end
    bus_if.core_w_en = 1'b0;
    if (aborted) begin
      bus_if.host_we = 1'b0;
      m_run  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      m_idle = 1'b1;
      tick();
      check_eq("post_rst_done", bus_if.done, 1'b0);
      check_eq("post_rst_ready", bus_if.cmd_ready, 1'b1);
    end else begin
      tick();
      bus_if.host_we = 1'b0;
      m_run  = 1'b0;
      m_idle = 1'b1;
      check_eq("done_pulse", bus_if.done, 1'b1);
      check_eq("done_err", bus_if.err, 1'b0);
      check_eq("done_ready", bus_if.cmd_ready, 1'b1);
      check_eq("done_busy", bus_if.busy, 1'b0);
      tick();
      check_eq("done_low", bus_if.done, 1'b0);
    end
  endtask

  task automatic run_timeout(input logic [7:0] w);
    int n;
    n = 0;
    accept(2'd1, 1'b0, 8'd3, 8'd4, w);
    for (int k = 1; k <= TIMEOUT + 10; k++) begin
      tick();
      if (k == 1) m_run = 1'b1;
      if (bus_if.done === 1'b1) begin
        n = k;
        break;
      end
    end
    m_run  = 1'b0;
    m_idle = 1'b1;
    check_eq("to_cycles", n, TIMEOUT + 1);
    check_eq("to_err", bus_if.err, 1'b1);
    check_eq("to_ready", bus_if.cmd_ready, 1'b1);
    check_eq("to_busy", bus_if.busy, 1'b0);
    tick();
    check_eq("to_done_low", bus_if.done, 1'b0);
    check_eq("to_err_sticky", bus_if.err, 1'b1);
  endtask

  task automatic verify_all();
    bus_if.host_we = 1'b0;
    for (int a = 0; a < 256; a++) begin
      bus_if.host_addr = 8'(a);
      tick();
    end
  endtask

  initial begin
    logic [95:0] keep64;
    total  = 0;
    bad    = 0;
    m_idle = 1'b1;
    m_run  = 1'b0;
    chk_rd = 1'b0;
    rst    = 1'b1;
    bus_if.cmd_valid      = 1'b0;
    bus_if.cmd_mode       = 2'd0;
    bus_if.cmd_add_or_sub = 1'b0;
    bus_if.cmd_src_a      = 8'd0;
    bus_if.cmd_src_b      = 8'd0;
    bus_if.cmd_dst        = 8'd0;
    bus_if.host_we        = 1'b0;
    bus_if.host_addr      = 8'd0;
    bus_if.host_wdata     = 96'd0;
    bus_if.core_r_addr    = 8'd0;
    bus_if.core_w_addr    = 8'd0;
    bus_if.core_w_data    = 96'd0;
    bus_if.core_w_en      = 1'b0;
    #12;
    check_eq("rst_ready0", bus_if.cmd_ready, 1'b1);
    check_eq("rst_busy0", bus_if.busy, 1'b0);
    check_eq("rst_done0", bus_if.done, 1'b0);
    check_eq("rst_err0", bus_if.err, 1'b0);
    check_eq("rst_start0", bus_if.core_start, 1'b0);
    check_fields(2'd0, 1'b0, 8'd0, 8'd0, 8'd0);
    check_eq("rst_hrd0", bus_if.host_rdata, 96'd0);
    check_eq("rst_crd0", bus_if.core_r_data, 96'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int a = 0; a < 256; a++) begin
      bus_if.host_we    = 1'b1;
      bus_if.host_addr  = 8'(a);
      bus_if.host_wdata = rand96();
      tick();
    end
    bus_if.host_we = 1'b0;
    tick();
    chk_rd = 1'b1;

    bus_if.host_we    = 1'b1;
    bus_if.host_addr  = 8'd5;
    bus_if.host_wdata = 96'hABC;
    tick();
    bus_if.host_we = 1'b0;
    tick();
    check_eq("rd5", bus_if.host_rdata, 96'hABC);

    // same-address write and read: tick expects the pre-write contents
    bus_if.host_we    = 1'b1;
    bus_if.host_addr  = 8'd9;
    bus_if.host_wdata = rand96();
    tick();
    bus_if.host_we = 1'b0;
    tick();

    run_cmd(2'd0, 1'b0, 8'd0, 8'd0, 8'd64, 32, 3, 8'd200, -1);
    verify_all();

    keep64 = mem_m[64];
    run_cmd(2'd2, 1'b0, 8'd0, 8'd32, 8'd128, 20, 2, 8'd64, -1);
    bus_if.host_addr = 8'd64;
    tick();
    check_eq("ram64_kept", bus_if.host_rdata, keep64);
    verify_all();

    run_timeout(8'd40);

    for (int r = 0; r < 6; r++) begin
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(1, 40), $urandom_range(0, 8), 8'($urandom), -1);
      verify_all();
    end

    run_cmd(2'd1, 1'b0, 8'd10, 8'd20, 8'd30, 20, 1, 8'd0, 10);
    run_cmd(2'd3, 1'b1, 8'd0, 8'd32, 8'd160, 16, 2, 8'd5, -1);
    verify_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
